// File: rtl/hamming_pkg.sv
// Shared constants for the Hamming(21,16) encoder: widths, parity positions,
// data-to-codeword index map and parity coverage masks.
package hamming_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned CODE_W  = 21;
  localparam int unsigned NUM_PAR = 5;

  localparam int unsigned PAR_IDX [NUM_PAR] = '{0, 1, 3, 7, 15};

  localparam int unsigned DATA_IDX [DATA_W] = '{
    2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 16, 17, 18, 19, 20
  };

  // Bit k of mask p is set when codeword index k contributes to parity p.
  localparam logic [CODE_W-1:0] PAR_MASK [NUM_PAR] = '{
    21'h155554, 21'h066664, 21'h187870, 21'h007F00, 21'h1F0000
  };

  // One-hot flip for Hamming position 1..21; any other position flips nothing.
  function automatic logic [CODE_W-1:0] flip_mask(input logic en, input logic [4:0] pos);
    logic [CODE_W-1:0] m;
    m = '0;
    if (en && (pos >= 5'd1) && (pos <= 5'd21)) begin
      m[pos - 5'd1] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_enc_comb.sv
// Purely combinational Hamming(21,16) encoder: 16-bit data to 21-bit codeword.
module hamming_enc_comb
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [CODE_W-1:0] code_o
);

  logic [CODE_W-1:0] placed;

  always_comb begin
    placed = '0;
    for (int i = 0; i < DATA_W; i++) begin
      placed[DATA_IDX[i]] = data_i[i];
    end
    code_o = placed;
    for (int k = 0; k < NUM_PAR; k++) begin
      code_o[PAR_IDX[k]] = ^(placed & PAR_MASK[k]);
    end
  end

endmodule

// File: rtl/hamming_encoder.sv
// Streaming Hamming(21,16) encoder with a two-stage elastic pipeline.
// Optional error injection is enabled by defining HAMMING_ERR_INJECT_EN.
module hamming_encoder
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic              err_inj_en,
  input  logic [4:0]        err_inj_pos,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [15:0]       word_count
);

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s2_valid_q, s2_valid_d;
  logic [CODE_W-1:0] s2_code_q, s2_code_d;
  logic [15:0]       count_q, count_d;
  logic [CODE_W-1:0] enc_code;
  logic [CODE_W-1:0] s2_load_code;
  logic              s1_adv, in_fire, out_fire;

  hamming_enc_comb u_enc (
    .data_i (s1_data_q),
    .code_o (enc_code)
  );

`ifdef HAMMING_ERR_INJECT_EN
  logic       s1_inj_en_q, s1_inj_en_d;
  logic [4:0] s1_inj_pos_q, s1_inj_pos_d;

  always_comb begin
    s1_inj_en_d  = s1_inj_en_q;
    s1_inj_pos_d = s1_inj_pos_q;
    if (in_fire) begin
      s1_inj_en_d  = err_inj_en;
      s1_inj_pos_d = err_inj_pos;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_inj_en_q  <= 1'b0;
      s1_inj_pos_q <= '0;
    end else begin
      s1_inj_en_q  <= s1_inj_en_d;
      s1_inj_pos_q <= s1_inj_pos_d;
    end
  end

  assign s2_load_code = enc_code ^ flip_mask(s1_inj_en_q, s1_inj_pos_q);
`else
  assign s2_load_code = enc_code;
`endif

  // in_ready depends on out_ready so a full pipeline refills in the drain cycle.
  assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_data;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_code_d  = s2_code_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_code_d  = s2_load_code;
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (out_fire && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_code_q  <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_code_q  <= s2_code_d;
      count_q    <= count_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_code   = s2_code_q;
  assign word_count = count_q;

endmodule
